// File: rtl/lh_pkg.sv
// -----------------------------------------------------------------------------
// lh_pkg - shared types and constants for the light-hash round sequencer.
//   state_t        : sequencer FSM states
//   lane_t         : lane index (one of the eight digest bytes)
//   DEFAULT_*      : default ROUNDS / IV values
//   ASCII_*        : accepted character ranges for the optional character check
//   sbox()         : AES forward S-box
//   is_valid_char(): byte lies in 0-9, A-Z or a-z
// -----------------------------------------------------------------------------
package lh_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;
  typedef logic [2:0] lane_t;

  localparam int unsigned DEFAULT_ROUNDS = 32;
  localparam logic [63:0] DEFAULT_IV     = 64'h0;

  localparam logic [7:0] ASCII_DIGIT_LO = 8'h30;
  localparam logic [7:0] ASCII_DIGIT_HI = 8'h39;
  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
  localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;

  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x); ~x is 255-x for an 8-bit value.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= ASCII_DIGIT_LO) && (c <= ASCII_DIGIT_HI)) ||
           ((c >= ASCII_UPPER_LO) && (c <= ASCII_UPPER_HI)) ||
           ((c >= ASCII_LOWER_LO) && (c <= ASCII_LOWER_HI));
  endfunction

endpackage

// File: rtl/lh_round_sequencer_if.sv
// -----------------------------------------------------------------------------
// lh_round_sequencer_if - message input stream and digest output stream.
//   msg_data/msg_valid/msg_last/msg_ready : byte-wide input, valid/ready
//   dig_data/dig_valid/dig_ready          : 64-bit digest output, valid/ready
//   dig_err                               : message contained a rejected byte
//   busy                                  : sequencer not in IDLE
//   modport slave  : the sequencer side
//   modport master : producer/consumer side
// -----------------------------------------------------------------------------
interface lh_round_sequencer_if;
  logic [7:0]  msg_data;
  logic        msg_valid;
  logic        msg_last;
  logic        msg_ready;
  logic [63:0] dig_data;
  logic        dig_valid;
  logic        dig_ready;
  logic        dig_err;
  logic        busy;

  modport slave (
    input  msg_data, msg_valid, msg_last, dig_ready,
    output msg_ready, dig_data, dig_valid, dig_err, busy
  );

  modport master (
    output msg_data, msg_valid, msg_last, dig_ready,
    input  msg_ready, dig_data, dig_valid, dig_err, busy
  );
endinterface

// File: rtl/lh_step_unit.sv
// -----------------------------------------------------------------------------
// lh_step_unit - combinational lane update: SBOX(rotl(src ^ msg, lane)).
//   src_i  : current value of the source digest byte H[(lane+2) mod 8]
//   msg_i  : message byte being absorbed
//   lane_i : lane index, also the rotate amount
//   res_o  : new value for H[lane]
// -----------------------------------------------------------------------------
module lh_step_unit
  import lh_pkg::*;
(
  input  logic [7:0] src_i,
  input  logic [7:0] msg_i,
  input  lane_t      lane_i,
  output logic [7:0] res_o
);

  logic [7:0]  mixed;
  logic [15:0] doubled;

  // Rotate by shifting a doubled copy; the upper byte is the rotated value.
  assign mixed   = src_i ^ msg_i;
  assign doubled = {mixed, mixed} << lane_i;
  assign res_o   = sbox(doubled[15:8]);

endmodule

// File: rtl/lh_round_sequencer.sv
// -----------------------------------------------------------------------------
// lh_round_sequencer - iterative light-hash controller. Absorbs one message
// byte per visit to IDLE, then spends ROUNDS*8 cycles updating one digest lane
// per cycle through a single shared lh_step_unit. After the last byte the
// digest is held on the output stream until accepted.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : lh_round_sequencer_if.slave (message in, digest out, status)
// Parameters: ROUNDS (1..255) rounds per byte, IV initial digest state.
// Optional: define LH_CHAR_CHECK_EN to skip bytes outside 0-9/A-Z/a-z and
// flag them on dig_err.
// -----------------------------------------------------------------------------
module lh_round_sequencer
  import lh_pkg::*;
#(
  parameter int unsigned ROUNDS = DEFAULT_ROUNDS,
  parameter logic [63:0] IV     = DEFAULT_IV
) (
  input logic                clk,
  input logic                rst,
  lh_round_sequencer_if.slave bus
);

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

  state_t           state_q, state_d;
  logic [0:7][7:0]  h_q, h_d;       // h_q[0] is H[0], the digest MSB
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  lane_t            lane_q, lane_d;
  logic [7:0]       round_q, round_d;
  logic [63:0]      dig_q, dig_d;
  logic [7:0]       step_res;
  logic             accept;
  logic             final_step;
`ifdef LH_CHAR_CHECK_EN
  logic             err_q, err_d;
`endif

  assign accept     = (state_q == IDLE) && bus.msg_valid;
  assign final_step = (lane_q == 3'd7) && (round_q == LAST_ROUND);

  // Lanes 6 and 7 read H[0]/H[1] already rewritten this round.
  lh_step_unit u_step (
    .src_i  (h_q[lane_q + 3'd2]),
    .msg_i  (byte_q),
    .lane_i (lane_q),
    .res_o  (step_res)
  );

  // State register
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: each signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef LH_CHAR_CHECK_EN
          if (!is_valid_char(bus.msg_data)) state_d = bus.msg_last ? OUT : IDLE;
          else                              state_d = ROUND;
`else
          state_d = ROUND;
`endif
        end
      end
      ROUND:   if (final_step) state_d = last_q ? OUT : IDLE;
      OUT:     if (bus.dig_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.msg_ready = (state_q == IDLE) && !rst;
    bus.busy      = (state_q != IDLE);
    bus.dig_valid = (state_q == OUT);
    bus.dig_data  = dig_q;
`ifdef LH_CHAR_CHECK_EN
    bus.dig_err   = err_q;
`else
    bus.dig_err   = 1'b0;
`endif
  end

  // Datapath next values
  always_comb begin
    h_d     = h_q;
    byte_d  = byte_q;
    last_d  = last_q;
    lane_d  = lane_q;
    round_d = round_q;
    dig_d   = dig_q;
`ifdef LH_CHAR_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          byte_d  = bus.msg_data;
          last_d  = bus.msg_last;
          lane_d  = '0;
          round_d = '0;
`ifdef LH_CHAR_CHECK_EN
          if (!is_valid_char(bus.msg_data)) err_d = 1'b1;
`endif
        end
      end
      ROUND: begin
        h_d[lane_q] = step_res;
        lane_d      = lane_q + 3'd1;
        if (lane_q == 3'd7) round_d = round_q + 8'd1;
      end
      OUT: begin
        if (bus.dig_ready) begin
          h_d = IV;
`ifdef LH_CHAR_CHECK_EN
          err_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase
    // Capture the digest on entry to OUT so it stays frozen while presented.
    if ((state_q != OUT) && (state_d == OUT)) dig_d = h_d;
  end

  // NOTE: H is eight bytes of discrete flops, not a RAM, so it is reset
  // straight to IV; a partial message is discarded by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= IV;
      byte_q  <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      round_q <= '0;
      dig_q   <= '0;
`ifdef LH_CHAR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      h_q     <= h_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      lane_q  <= lane_d;
      round_q <= round_d;
      dig_q   <= dig_d;
`ifdef LH_CHAR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_lh_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lh_round_sequencer - directed bench for lh_round_sequencer. Two
// instances: ROUNDS=1 for the hand-computed vector and ROUNDS=32 for the
// multi-byte, stall, reset, character-check and streaming scenarios. Multi-
// byte digests come from a reference model that derives the S-box from the
// GF(2^8) inverse and affine map. Honours LH_CHAR_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lh_round_sequencer;

  logic clk;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   acc_cnt      = 0;
  int   t_acc        = 0;
  logic [7:0] ref_tab [256];

  lh_round_sequencer_if if1 ();
  lh_round_sequencer_if if32 ();

  lh_round_sequencer #(.ROUNDS(1), .IV(64'h0)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  lh_round_sequencer #(.ROUNDS(32), .IV(64'h0)) u_dut32 (
    .clk (clk), .rst (rst), .bus (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (if32.msg_valid && if32.msg_ready) acc_cnt <= acc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic ref_valid(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic logic [63:0] model_hash(input logic [7:0] m [4], input int n,
                                             input int rounds);
    logic [7:0] h [8];
    logic [7:0] t;
    for (int i = 0; i < 8; i++) h[i] = 8'h00;
    for (int k = 0; k < n; k++) begin
`ifdef LH_CHAR_CHECK_EN
      if (!ref_valid(m[k])) continue;
`endif
      for (int r = 0; r < rounds; r++)
        for (int i = 0; i < 8; i++) begin
          t = h[(i + 2) % 8] ^ m[k];
          h[i] = ref_tab[rotl8(t, i)];
        end
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send32(input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    if32.msg_data  = b;
    if32.msg_last  = last;
    if32.msg_valid = 1'b1;
    while (!if32.msg_ready && guard < 2000) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    if (guard >= 2000) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: msg_ready never rose for byte %h", b);
    end
    @(posedge clk);
    @(negedge clk);
    if32.msg_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!if32.msg_ready && n < 2000) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic wait_digest(output int n);
    n = 0;
    while (!if32.dig_valid && n < 2000) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!if32.dig_valid) begin
      tests_run++; tests_failed++;
      $display("FAIL digest_timeout: dig_valid never rose");
    end
  endtask

  task automatic ack_digest();
    if32.dig_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if32.dig_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    if1.msg_data = 8'h00; if1.msg_valid = 1'b0; if1.msg_last = 1'b0; if1.dig_ready = 1'b0;
    if32.msg_data = 8'h00; if32.msg_valid = 1'b0; if32.msg_last = 1'b0; if32.dig_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (if32.msg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready_low: got %b want 0", if32.msg_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (if32.msg_ready !== 1'b1 || if32.busy !== 1'b0 || if32.dig_valid !== 1'b0 ||
        if32.dig_data !== 64'h0 || if32.dig_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b busy=%b dv=%b dd=%h err=%b want 1 0 0 0 0",
               if32.msg_ready, if32.busy, if32.dig_valid, if32.dig_data, if32.dig_err);
    end
    @(negedge clk);
  endtask

  task automatic test_rounds1();
    int n;
    if1.msg_data = 8'h00; if1.msg_last = 1'b1; if1.msg_valid = 1'b1;
    tests_run++;
    if (if1.msg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL r1_ready: got %b want 1", if1.msg_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if1.msg_valid = 1'b0;
    n = 0;
    while (!if1.dig_valid && n < 100) begin
      @(posedge clk); @(negedge clk); n++;
    end
    tests_run++;
    if (n !== 8) begin
      tests_failed++; $display("FAIL r1_latency: got %0d cycles want 8", n);
    end
    tests_run++;
    if (if1.dig_data !== 64'h63636363636361C8 || if1.dig_err !== 1'b0 || if1.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL r1_digest: got %h err=%b busy=%b want 63636363636361c8 0 1",
               if1.dig_data, if1.dig_err, if1.busy);
    end
    if1.dig_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.dig_ready = 1'b0;
    tests_run++;
    if (if1.dig_valid !== 1'b0 || if1.msg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL r1_ack: dv=%b ready=%b want 0 1", if1.dig_valid, if1.msg_ready);
    end
  endtask

  task automatic test_ab1(input logic [63:0] exp);
    int n, t0;
    send32("A", 1'b0);
    t0 = t_acc;
    wait_ready(n);
    tests_run++;
    if (n !== 256) begin
      tests_failed++; $display("FAIL ab1_busy_A: got %0d want 256", n);
    end
    send32("b", 1'b0);
    wait_ready(n);
    tests_run++;
    if (n !== 256) begin
      tests_failed++; $display("FAIL ab1_busy_b: got %0d want 256", n);
    end
    send32("1", 1'b1);
    wait_digest(n);
    tests_run++;
    if (cyc - t0 !== 770) begin
      tests_failed++; $display("FAIL ab1_latency: got %0d want 770", cyc - t0);
    end
    tests_run++;
    if (if32.dig_data !== exp) begin
      tests_failed++; $display("FAIL ab1_digest: got %h want %h", if32.dig_data, exp);
    end
  endtask

  task automatic test_hold(input logic [63:0] exp);
    int bad;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); @(negedge clk);
      if (!if32.dig_valid || if32.dig_data !== exp || if32.msg_ready) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad);
    end
    ack_digest();
    tests_run++;
    if (if32.msg_ready !== 1'b1 || if32.dig_valid !== 1'b0 || if32.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_ack: ready=%b dv=%b busy=%b want 1 0 0",
               if32.msg_ready, if32.dig_valid, if32.busy);
    end
    test_ab1(exp);   // same digest again only if H returned to IV
    ack_digest();
  endtask

  task automatic test_reset_mid(input logic [63:0] exp_a);
    int n;
    send32("A", 1'b1);
    repeat (83) @(posedge clk);   // 83 lane updates: round 10, lane 3 next
    @(negedge clk);
    tests_run++;
    if (if32.busy !== 1'b1) begin
      tests_failed++; $display("FAIL mid_busy: got %b want 1", if32.busy);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (if32.busy !== 1'b0 || if32.msg_ready !== 1'b0 || if32.dig_valid !== 1'b0 ||
        if32.dig_data !== 64'h0 || if32.dig_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy=%b ready=%b dv=%b dd=%h err=%b want 0 0 0 0 0",
               if32.busy, if32.msg_ready, if32.dig_valid, if32.dig_data, if32.dig_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send32("A", 1'b1);
    wait_digest(n);
    tests_run++;
    if (if32.dig_data !== exp_a) begin
      tests_failed++; $display("FAIL mid_fresh_digest: got %h want %h", if32.dig_data, exp_a);
    end
    ack_digest();
  endtask

  task automatic test_char_check(input logic [63:0] exp);
    int n;
    logic exp_err;
    int   exp_busy;
`ifdef LH_CHAR_CHECK_EN
    exp_err = 1'b1; exp_busy = 0;
`else
    exp_err = 1'b0; exp_busy = 256;
`endif
    send32("A", 1'b0);
    wait_ready(n);
    send32("#", 1'b0);
    wait_ready(n);
    tests_run++;
    if (n !== exp_busy) begin
      tests_failed++; $display("FAIL char_busy: got %0d want %0d", n, exp_busy);
    end
    send32("B", 1'b1);
    wait_digest(n);
    tests_run++;
    if (if32.dig_err !== exp_err) begin
      tests_failed++; $display("FAIL char_err: got %b want %b", if32.dig_err, exp_err);
    end
    tests_run++;
    if (if32.dig_data !== exp) begin
      tests_failed++; $display("FAIL char_digest: got %h want %h", if32.dig_data, exp);
    end
    ack_digest();
    tests_run++;
    if (if32.dig_err !== 1'b0) begin
      tests_failed++; $display("FAIL char_err_clear: got %b want 0", if32.dig_err);
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] m [4], input logic [63:0] exp);
    int a0, n, guard;
    a0 = acc_cnt;
    if32.msg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if32.msg_data = m[k];
      if32.msg_last = (k == 2);
      guard = 0;
      while (!if32.msg_ready && guard < 2000) begin
        @(posedge clk); @(negedge clk); guard++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if32.msg_valid = 1'b0;
    wait_digest(n);
    tests_run++;
    if (acc_cnt - a0 !== 3) begin
      tests_failed++; $display("FAIL b2b_accepts: got %0d want 3", acc_cnt - a0);
    end
    tests_run++;
    if (if32.dig_data !== exp) begin
      tests_failed++; $display("FAIL b2b_digest: got %h want %h", if32.dig_data, exp);
    end
    ack_digest();
  endtask

  initial begin
    logic [7:0] m [4];
    logic [63:0] exp_ab1, exp_a, exp_char, exp_b2b;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      ref_tab[x] = s;
    end
    m = '{"A", "b", "1", 8'h00}; exp_ab1  = model_hash(m, 3, 32);
    m = '{"A", 8'h00, 8'h00, 8'h00}; exp_a = model_hash(m, 1, 32);
    m = '{"A", "#", "B", 8'h00}; exp_char = model_hash(m, 3, 32);
    m = '{"Q", "7", "z", 8'h00}; exp_b2b  = model_hash(m, 3, 32);

    test_reset();
    test_rounds1();
    test_ab1(exp_ab1);
    test_hold(exp_ab1);
    test_reset_mid(exp_a);
    test_char_check(exp_char);
    m = '{"Q", "7", "z", 8'h00};
    test_back_to_back(m, exp_b2b);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
